// File: rtl/rv_pkg.sv
// RV32I decode constants: major opcodes, ALU operation codes, immediate formats and M-extension codes.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_M   = 7'b0000001;

  // M-extension codes: funct3 travels alongside to pick the signed/unsigned/high variant.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_MUL    = 4'd11,
    ALU_MULH   = 4'd12,
    ALU_DIV    = 4'd13,
    ALU_REM    = 4'd14
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
    imm_fmt_t fmt;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // alt is funct7[5]; it means SUB only for register-register ops, SRA for both.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt, input logic is_op);
    alu_op_t op;
    case (f3)
      3'b000:  op = (alt && is_op) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_t m_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:          op = ALU_MUL;
      3'b100, 3'b101:  op = ALU_DIV;
      3'b110, 3'b111:  op = ALU_REM;
      default:         op = ALU_MULH;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction: picks the I/S/B/U/J layout from the opcode and sign-extends to XLEN.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  imm_fmt_t    fmt;
  logic [31:0] imm32;

  always_comb begin
    fmt   = imm_fmt_of(instr[6:0]);
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage, one register deep: valid/ready on both sides, flush redirect, optional load-use bubble (HAZ_EN).
// Define RV_M_EXT_EN to decode the M extension; otherwise those encodings are flagged illegal.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit HAZ_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_illegal
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] dec_imm;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (dec_imm)
  );

  alu_op_t dec_alu_op;
  logic    dec_alu_src, dec_mem_read, dec_mem_write, dec_reg_write;
  logic    dec_branch, dec_jal, dec_jalr, dec_illegal, dec_uses_rs2;

  always_comb begin
    dec_alu_op    = ALU_ADD;
    dec_alu_src   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_reg_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jal       = 1'b0;
    dec_jalr      = 1'b0;
    dec_illegal   = 1'b0;
    dec_uses_rs2  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_uses_rs2 = 1'b1;
        if (funct7 == FUNCT7_M) begin
`ifdef RV_M_EXT_EN
          dec_alu_op    = m_op(funct3);
          dec_reg_write = 1'b1;
`else
          dec_illegal   = 1'b1;
`endif
        end else begin
          dec_alu_op    = arith_op(funct3, funct7[5], 1'b1);
          dec_reg_write = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_alu_op    = arith_op(funct3, funct7[5], 1'b0);
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_uses_rs2  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_alu_op    = ALU_SUB;
        dec_branch    = 1'b1;
        dec_uses_rs2  = 1'b1;
      end
      OPC_JAL: begin
        dec_alu_src   = 1'b1;
        dec_jal       = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec_alu_src   = 1'b1;
        dec_jalr      = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_LUI: begin
        dec_alu_op    = ALU_PASS_B;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec_reg_write = 1'b0;
  end

  // The held output register doubles as the interlock state: a held load is the only hazard source.
  logic hazard, accept;

  always_comb begin
    hazard = 1'b0;
    if (HAZ_EN && out_valid && out_mem_read && (out_rd != 5'd0) && in_valid)
      hazard = (out_rd == rs1) || (dec_uses_rs2 && (out_rd == rs2));
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_funct3    <= '0;
      out_alu_op    <= ALU_ADD;
      out_alu_src   <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_reg_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jal       <= 1'b0;
      out_jalr      <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_imm       <= dec_imm;
      out_rd        <= rd;
      out_rs1       <= rs1;
      out_rs2       <= rs2;
      out_funct3    <= funct3;
      out_alu_op    <= dec_alu_op;
      out_alu_src   <= dec_alu_src;
      out_mem_read  <= dec_mem_read;
      out_mem_write <= dec_mem_write;
      out_reg_write <= dec_reg_write;
      out_branch    <= dec_branch;
      out_jal       <= dec_jal;
      out_jalr      <= dec_jalr;
      out_illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomized scoreboard bench for id_stage with directed RV32I corner cases up front.
module tb_id_stage;
  import rv_pkg::*;

  localparam int XLEN = 32;
`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [3:0]      out_alu_op;
  logic            out_alu_src, out_mem_read, out_mem_write, out_reg_write;
  logic            out_branch, out_jal, out_jalr, out_illegal;

  always #5 clk = ~clk;

  id_stage #(.XLEN(XLEN), .HAZ_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_alu_op(out_alu_op),
    .out_alu_src(out_alu_src), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_branch(out_branch), .out_jal(out_jal),
    .out_jalr(out_jalr), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, branch, jal, jalr, illegal;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  bit   pend_vld = 1'b0;
  int   checks = 0, failures = 0, stalls = 0, accepts = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] hi;
    hi = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | hi) : (v & ~hi);
  endfunction

  // Reference decoder written straight from the RV32I encoding tables.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    logic [3:0] base [8];
    logic [2:0] f3;
    logic       alt;
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3  = ins[14:12];
    alt = ins[30];
    e = '0;
    e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = f3;
    e.alu_op = ALU_ADD;
    case (ins[6:0])
      7'h33: begin
        if (ins[31:25] == 7'h01) begin
          if (M_EN) begin
            e.reg_write = 1'b1;
            if (f3 == 0) e.alu_op = ALU_MUL;
            else if (f3 < 4) e.alu_op = ALU_MULH;
            else if (f3 < 6) e.alu_op = ALU_DIV;
            else e.alu_op = ALU_REM;
          end else e.illegal = 1'b1;
        end else begin
          e.alu_op = (alt && f3 == 0) ? ALU_SUB : (alt && f3 == 5) ? ALU_SRA : base[f3];
          e.reg_write = 1'b1;
        end
      end
      7'h13: begin
        e.imm = sext(ins >> 20, 12);
        e.alu_op = (alt && f3 == 5) ? ALU_SRA : base[f3];
        e.alu_src = 1'b1; e.reg_write = 1'b1;
      end
      7'h03: begin e.imm = sext(ins >> 20, 12); e.alu_src = 1'b1; e.mem_read = 1'b1; e.reg_write = 1'b1; end
      7'h23: begin e.imm = sext({ins[31:25], ins[11:7]}, 12); e.alu_src = 1'b1; e.mem_write = 1'b1; end
      7'h63: begin
        e.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        e.branch = 1'b1; e.alu_op = ALU_SUB;
      end
      7'h6F: begin
        e.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        e.jal = 1'b1; e.alu_src = 1'b1; e.reg_write = 1'b1;
      end
      7'h67: begin e.imm = sext(ins >> 20, 12); e.jalr = 1'b1; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      7'h37: begin e.imm = ins & 32'hFFFF_F000; e.alu_op = ALU_PASS_B; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      7'h17: begin e.imm = ins & 32'hFFFF_F000; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    if (e.rd == 0) e.reg_write = 1'b0;
    return e;
  endfunction

  function automatic logic [63:0] ctrl_of(input exp_t e);
    return {e.rd, e.rs1, e.rs2, e.f3, e.alu_op, e.alu_src, e.mem_read, e.mem_write,
            e.reg_write, e.branch, e.jal, e.jalr, e.illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [12];
    logic [6:0]  f7s [3];
    logic [31:0] w;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
    f7s  = '{7'h00, 7'h20, 7'h01};
    w = $urandom;
    w[6:0]   = opcs[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33) w[31:25] = f7s[$urandom_range(0, 2)];
    return w;
  endfunction

  // One cycle of stimulus; the item accepted here is queued as expected output from the next cycle.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit fl, input bit ordy, input bit rst);
    exp_t e;
    bit   haz, exp_rdy, uses_rs2;
    @(posedge clk);
    #1;
    if (pend_vld) begin sb.push_back(pend); pend_vld = 1'b0; end
    in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy; rst_n = !rst;
    #1;
    e = model(ins, pc);
    uses_rs2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    haz = 1'b0;
    if (sb.size() != 0 && v && sb[0].mem_read && sb[0].rd != 0)
      haz = (sb[0].rd == e.rs1) || (uses_rs2 && sb[0].rd == e.rs2);
    exp_rdy = (sb.size() == 0 || ordy) && !haz;
    if (!rst) begin
      check("in_ready", in_ready, exp_rdy);
      if (haz) stalls++;
      if (v && exp_rdy && !fl) begin pend = e; pend_vld = 1'b1; accepts++; end
    end
  endtask

  // Monitor: compares every presented output with the scoreboard head, independent of the driver.
  initial begin
    exp_t h;
    forever begin
      @(posedge clk);
      #3;
      check("out_valid", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0) begin
        h = sb[0];
        check("pc_imm", {out_pc, out_imm}, {h.pc, h.imm});
        check("ctrl", {out_rd, out_rs1, out_rs2, out_funct3, out_alu_op, out_alu_src, out_mem_read,
                       out_mem_write, out_reg_write, out_branch, out_jal, out_jalr, out_illegal},
              ctrl_of(h));
      end
      if (!rst_n) sb.delete();
      else if (sb.size() != 0 && (out_ready || flush)) void'(sb.pop_front());
    end
  end

  initial begin
    int s0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    #2;
    check("rst_state", {out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_funct3, out_alu_op,
                        out_alu_src, out_mem_read, out_mem_write, out_reg_write, out_branch,
                        out_jal, out_jalr, out_illegal}, '0);

    // ADD x3,x1,x2
    step(1, 32'h002081B3, 32'h100, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    #2;
    check("add_vld", out_valid, 1);
    check("add_alu", out_alu_op, ALU_ADD);
    check("add_rw_rd", {out_reg_write, out_rd}, {1'b1, 5'd3});

    // LW x5,0(x1) then ADD x6,x5,x5: one bubble
    s0 = stalls;
    step(1, 32'h0000A283, 32'h104, 0, 1, 0);
    step(1, 32'h00528333, 32'h108, 0, 1, 0);
    step(1, 32'h00528333, 32'h108, 0, 1, 0);
    #2;
    check("lu_bubble", out_valid, 0);
    step(0, 0, 0, 0, 1, 0);
    #2;
    check("lu_add_out", {out_valid, out_rd}, {1'b1, 5'd6});
    check("lu_stalls", stalls - s0, 1);

    // BEQ x0,x0,-4
    step(1, 32'hFE000EE3, 32'h200, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    #2;
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_ctl", {out_branch, out_alu_op}, {1'b1, 4'(ALU_SUB)});

    // Stall three cycles with a held output, a new instruction waiting
    step(1, 32'h002081B3, 32'h300, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h00310233, 32'h304, 0, 0, 0);
    #2;
    check("stall_pc", {out_valid, out_pc}, {1'b1, 32'h300});
    step(1, 32'h00310233, 32'h304, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Flush with a held output and an incoming instruction
    step(1, 32'h002081B3, 32'h400, 0, 1, 0);
    step(1, 32'h00310233, 32'h404, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    #2;
    check("flush_clear", out_valid, 0);

    // Unknown opcode and MUL
    step(1, 32'h0000017F, 32'h500, 0, 1, 0);
    step(1, 32'h02208033, 32'h504, 0, 1, 0);
    #2;
    check("ill_7f", {out_illegal, out_reg_write, out_mem_read, out_mem_write}, 4'b1000);
    step(0, 0, 0, 0, 1, 0);
    #2;
    check("ill_mul", {out_illegal, out_reg_write}, {!M_EN, 1'b0});

    // Reset in the middle of a transfer
    step(1, 32'h00A00093, 32'h600, 0, 0, 0);
    step(1, 32'h00B00113, 32'h604, 0, 1, 1);
    step(1, 32'h00C00193, 32'h608, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    #2;
    check("post_rst_accept", {out_valid, out_pc}, {1'b1, 32'h608});

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    check("random_stalls_seen", stalls > 1, 1);
    check("drained", sb.size() + int'(pend_vld), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
